// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared scheduler state encoding and default sizing constants.
package tx_sched_pkg;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_GAP_CYCLES  = 100;
    localparam int DEF_ACK_TIMEOUT = 16;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous per-channel sample FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr, r_rd;
    logic          w_pop, w_push;
    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin two-channel sample scheduler feeding a pulse-width
// encoder, with ack timeout and an enforced inter-frame gap.
module tx_scheduler import tx_sched_pkg::*; #(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] ch0_data_in,
    input  logic                  ch0_valid_in,
    input  logic [DATA_WIDTH-1:0] ch1_data_in,
    input  logic                  ch1_valid_in,
    input  logic                  tx_busy_in,
    output logic [DATA_WIDTH-1:0] tx_data_out,
    output logic                  tx_start_out,
    output logic                  tx_channel_out,
    output logic [1:0]            drop_out,
    output logic                  timeout_out,
    output logic                  idle_out
);
    localparam int AW = $clog2(ACK_TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    state_t                r_state, w_next;
    logic [AW-1:0]         r_ack_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_last, r_ch;
    logic [DATA_WIDTH-1:0] r_data, w_d0, w_d1;
    logic [1:0]            r_drop, w_pop;
    logic                  w_full0, w_full1, w_empty0, w_empty1;
    logic                  w_take, w_grant, w_ack_to, w_gap_done;
    sample_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .i_clk(clk_in), .i_rst(rst_in), .i_push(ch0_valid_in), .i_data(ch0_data_in),
        .i_pop(w_pop[0]), .o_data(w_d0), .o_full(w_full0), .o_empty(w_empty0)
    );
    sample_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .i_clk(clk_in), .i_rst(rst_in), .i_push(ch1_valid_in), .i_data(ch1_data_in),
        .i_pop(w_pop[1]), .o_data(w_d1), .o_full(w_full1), .o_empty(w_empty1)
    );
    // On a tie, grant the channel that did not win last time.
    assign w_take     = (r_state == ST_IDLE) && (!w_empty0 || !w_empty1);
    assign w_grant    = (!w_empty0 && !w_empty1) ? !r_last : w_empty0;
    assign w_pop      = {w_take && w_grant, w_take && !w_grant};
    assign w_ack_to   = (r_state == ST_WAIT_ACK) && !tx_busy_in && (r_ack_cnt == AW'(ACK_TIMEOUT - 1));
    assign w_gap_done = int'(r_gap_cnt) + 1 >= GAP_CYCLES;
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = w_take ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:     w_next = ST_WAIT_ACK;
            ST_WAIT_ACK:  w_next = tx_busy_in ? ST_WAIT_DONE : (w_ack_to ? ST_GAP : ST_WAIT_ACK);
            ST_WAIT_DONE: w_next = tx_busy_in ? ST_WAIT_DONE : ST_GAP;
            ST_GAP:       w_next = w_gap_done ? ST_IDLE : ST_GAP;
            default:      w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_ack_cnt <= '0;
            r_gap_cnt <= '0;
            r_last    <= 1'b1;
            r_data    <= '0;
            r_ch      <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_next;
            r_ack_cnt <= (r_state == ST_WAIT_ACK) ? r_ack_cnt + 1'b1 : '0;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
            r_drop    <= {ch1_valid_in && w_full1 && !w_pop[1], ch0_valid_in && w_full0 && !w_pop[0]};
            if (w_take) begin
                r_data <= w_grant ? w_d1 : w_d0;
                r_ch   <= w_grant;
                r_last <= w_grant;
            end
        end
    end
    assign tx_data_out    = r_data;
    assign tx_channel_out = r_ch;
    assign tx_start_out   = r_state == ST_ISSUE;
    assign drop_out       = r_drop;
    assign timeout_out    = w_ack_to;
    assign idle_out       = (r_state == ST_IDLE) && w_empty0 && w_empty1;
endmodule
